// File: rtl/ntable_bg_fetch_ctrl_pkg.sv
// Shared definitions for the background tile fetch sequencer.
//  - Tile grid geometry (TILES_X x TILES_Y) and pixels per line.
//  - ROM address widths for name-table, attribute and pattern ROMs.
//  - Fetch FSM state encoding.
//  - Attribute-byte quadrant selection helper.
package ntable_bg_fetch_ctrl_pkg;

  localparam int TILES_X      = 32;
  localparam int TILES_Y      = 30;
  localparam int PIX_PER_LINE = TILES_X * 8;

  localparam int NT_AW = 10;
  localparam int AT_AW = 7;
  localparam int PT_AW = 12;

  localparam logic [4:0] LAST_COL = 5'(TILES_X - 1);
  localparam logic [8:0] LAST_PIX = 9'(PIX_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NT   = 3'd1,
    S_AT   = 3'd2,
    S_PT0  = 3'd3,
    S_PT1  = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  // One attribute byte covers a 4x4-tile block split into four 2x2
  // quadrants; row[1]/col[1] pick the quadrant (TL, TR, BL, BR).
  function automatic logic [1:0] at_quad_pal(input logic [7:0] at_byte,
                                             input logic       row1,
                                             input logic       col1);
    logic [1:0] pal;
    case ({row1, col1})
      2'b00:   pal = at_byte[1:0];
      2'b01:   pal = at_byte[3:2];
      2'b10:   pal = at_byte[5:4];
      default: pal = at_byte[7:6];
    endcase
    return pal;
  endfunction

endpackage

// File: rtl/ntable_bg_fetch_ctrl_if.sv
// Bus interface of the background fetch sequencer.
//  line_start/row/fine_y : line control from the sync/pixel counters
//  pix_adv               : consumer takes one pixel this cycle
//  nt_*/at_*/pt_*        : combinational ROM ports (address out, data back same cycle)
//  pix_color/pix_pal/pix_valid : pixel stream to the palette lookup
//  underrun/line_done    : status pulses
// Handshake: a pixel transfers in a cycle where pix_valid=1 and pix_adv=1
// (and line_start=0). pix_valid never waits on pix_adv; pix_adv with
// pix_valid=0 transfers nothing and, inside an active line, is an underrun.
// modport slave is the sequencer, modport master is its environment.
interface ntable_bg_fetch_ctrl_if;
  import ntable_bg_fetch_ctrl_pkg::*;

  logic             line_start;
  logic [4:0]       row;
  logic [2:0]       fine_y;
  logic             pix_adv;
  logic [NT_AW-1:0] nt_addr;
  logic [7:0]       nt_data;
  logic [AT_AW-1:0] at_addr;
  logic [7:0]       at_data;
  logic [PT_AW-1:0] pt_addr;
  logic [7:0]       pt_data;
  logic [1:0]       pix_color;
  logic [1:0]       pix_pal;
  logic             pix_valid;
  logic             underrun;
  logic             line_done;

  modport slave (
    input  line_start, row, fine_y, pix_adv, nt_data, at_data, pt_data,
    output nt_addr, at_addr, pt_addr, pix_color, pix_pal, pix_valid,
           underrun, line_done
  );

  modport master (
    output line_start, row, fine_y, pix_adv, nt_data, at_data, pt_data,
    input  nt_addr, at_addr, pt_addr, pix_color, pix_pal, pix_valid,
           underrun, line_done
  );
endinterface

// File: rtl/ntable_bg_fetch_ctrl_bg_tile_shifter.sv
// bg_tile_shifter: pixel output stage for one fetched tile plus one staged tile.
//  clear          : drop shifter and staging contents (new line / abort)
//  load, ld_*     : a freshly fetched tile (plane0, plane1, palette)
//  adv            : consumer advance request
//  pix_color/pix_pal/pix_valid : current leftmost pixel
//  empty          : staging register is free
//  shift_last     : this cycle's advance consumes the tile's 8th pixel
// A load goes straight into the shifter when it is empty or emptying this
// cycle, otherwise into staging. The loader never loads while staging is full.
module bg_tile_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] ld_p0,
  input  logic [7:0] ld_p1,
  input  logic [1:0] ld_pal,
  input  logic       adv,
  output logic [1:0] pix_color,
  output logic [1:0] pix_pal,
  output logic       pix_valid,
  output logic       empty,
  output logic       shift_last
);
  logic [7:0] sh0, sh1, st0, st1;
  logic [1:0] sh_pal, st_pal;
  logic       sh_valid, st_full;
  logic [2:0] cnt;
  logic       adv_eff, take_new, to_stage;

  assign adv_eff    = adv & sh_valid;
  assign shift_last = adv_eff & (cnt == 3'd7);
  assign take_new   = load & (~sh_valid | shift_last);
  assign to_stage   = load & ~take_new;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sh0 <= '0; sh1 <= '0; sh_pal <= '0; sh_valid <= 1'b0; cnt <= '0;
      st0 <= '0; st1 <= '0; st_pal <= '0; st_full <= 1'b0;
    end else begin
      if (take_new) begin
        sh0 <= ld_p0; sh1 <= ld_p1; sh_pal <= ld_pal;
        sh_valid <= 1'b1; cnt <= '0;
      end else if (shift_last) begin
        // Reload from staging on the same edge so the stream has no gap.
        if (st_full) begin
          sh0 <= st0; sh1 <= st1; sh_pal <= st_pal;
          st_full <= 1'b0;
        end else begin
          sh0 <= '0; sh1 <= '0; sh_valid <= 1'b0;
        end
        cnt <= '0;
      end else if (adv_eff) begin
        sh0 <= sh0 << 1;
        sh1 <= sh1 << 1;
        cnt <= cnt + 3'd1;
      end
      if (to_stage) begin
        st0 <= ld_p0; st1 <= ld_p1; st_pal <= ld_pal;
        st_full <= 1'b1;
      end
    end
  end

  assign pix_color = sh_valid ? {sh1[7], sh0[7]} : 2'b00;
  assign pix_pal   = sh_valid ? sh_pal : 2'b00;
  assign pix_valid = sh_valid;
  assign empty     = ~st_full;
endmodule

// File: rtl/ntable_bg_fetch_ctrl.sv
// ntable_bg_fetch_ctrl: background tile fetch sequencer.
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : slave side of ntable_bg_fetch_ctrl_if (line control, ROM ports,
//               pixel stream, underrun/line_done pulses)
//  dbg_state  : current fetch FSM state
// Per tile the FSM walks NT -> AT -> PT0 -> PT1, one ROM access per cycle.
// ROM addresses are registered and set on the edge entering the state that
// uses them, so they hold their last value in IDLE/WAIT.
module ntable_bg_fetch_ctrl
  import ntable_bg_fetch_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  ntable_bg_fetch_ctrl_if.slave bus,
  output state_t                dbg_state
);
  state_t           state;
  logic [4:0]       col, col_nxt, row_q;
  logic [2:0]       fy_q;
  logic [7:0]       tile, p0;
  logic [1:0]       pal;
  logic [NT_AW-1:0] nt_addr_q;
  logic [AT_AW-1:0] at_addr_q;
  logic [PT_AW-1:0] pt_addr_q;
  logic             underrun_q, line_done_q, line_active;
  logic [8:0]       px_cnt;

  logic       pix_valid, st_empty, shift_last;
  logic [1:0] pix_color, pix_pal;
  logic       sh_load, sh_adv, consume, load_direct;

  // line_start wins over pix_adv: nothing shifts or counts that cycle.
  assign sh_adv      = bus.pix_adv & ~bus.line_start;
  assign consume     = sh_adv & pix_valid & line_active;
  assign sh_load     = (state == S_PT1) & ~bus.line_start;
  assign load_direct = ~pix_valid | shift_last;
  assign col_nxt     = col + 5'd1;

  bg_tile_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (bus.line_start),
    .load       (sh_load),
    .ld_p0      (p0),
    .ld_p1      (bus.pt_data),
    .ld_pal     (pal),
    .adv        (sh_adv),
    .pix_color  (pix_color),
    .pix_pal    (pix_pal),
    .pix_valid  (pix_valid),
    .empty      (st_empty),
    .shift_last (shift_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      col         <= '0;
      row_q       <= '0;
      fy_q        <= '0;
      tile        <= '0;
      p0          <= '0;
      pal         <= '0;
      nt_addr_q   <= '0;
      at_addr_q   <= '0;
      pt_addr_q   <= '0;
      underrun_q  <= 1'b0;
      line_done_q <= 1'b0;
      line_active <= 1'b0;
      px_cnt      <= '0;
    end else begin
      // The line_start cycle itself counts as a starved advance.
      underrun_q  <= bus.pix_adv & (bus.line_start | (line_active & ~pix_valid));
      line_done_q <= 1'b0;
      if (bus.line_start) begin
        row_q       <= bus.row;
        fy_q        <= bus.fine_y;
        col         <= '0;
        state       <= S_NT;
        nt_addr_q   <= {bus.row, 5'd0};
        line_active <= 1'b1;
        px_cnt      <= '0;
      end else begin
        if (consume) begin
          px_cnt <= px_cnt + 9'd1;
          if (px_cnt == LAST_PIX) begin
            line_done_q <= 1'b1;
            line_active <= 1'b0;
          end
        end
        case (state)
          S_IDLE: state <= S_IDLE;
          S_NT: begin
            tile      <= bus.nt_data;
            at_addr_q <= {1'b0, row_q[4:2], col[4:2]};
            state     <= S_AT;
          end
          S_AT: begin
            pal       <= at_quad_pal(bus.at_data, row_q[1], col[1]);
            pt_addr_q <= {tile, 1'b0, fy_q};
            state     <= S_PT0;
          end
          S_PT0: begin
            p0        <= bus.pt_data;
            pt_addr_q <= {tile, 1'b1, fy_q};
            state     <= S_PT1;
          end
          S_PT1: begin
            if (col == LAST_COL) begin
              state <= S_IDLE;
            end else begin
              col <= col_nxt;
              // Tile went to the shifter: staging is free, keep fetching.
              if (load_direct) begin
                nt_addr_q <= {row_q, col_nxt};
                state     <= S_NT;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (st_empty || shift_last) begin
              nt_addr_q <= {row_q, col};
              state     <= S_NT;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.nt_addr   = nt_addr_q;
  assign bus.at_addr   = at_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pix_color = pix_color;
  assign bus.pix_pal   = pix_pal;
  assign bus.pix_valid = pix_valid;
  assign bus.underrun  = underrun_q;
  assign bus.line_done = line_done_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_ntable_bg_fetch_ctrl.sv
module tb_ntable_bg_fetch_ctrl;
  import ntable_bg_fetch_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ntable_bg_fetch_ctrl_if bus ();
  state_t dbg_state;

  ntable_bg_fetch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- ROM models ----------------
  logic [7:0] nt_rom [1024];
  logic [7:0] at_rom [128];
  logic [7:0] pt_rom [4096];

  assign bus.nt_data = nt_rom[bus.nt_addr];
  assign bus.at_data = at_rom[bus.at_addr];
  assign bus.pt_data = pt_rom[bus.pt_addr];

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int pix_seen    = 0;
  int under_cnt   = 0;
  int done_cnt    = 0;
  logic [1:0] obs_pal [256];
  logic [1:0] obs_col [256];

  logic [4:0] q_rows [3]  = '{5'd0, 5'd2, 5'd3};
  logic [1:0] q_pal0 [3]  = '{2'b00, 2'b10, 2'b10};
  logic [1:0] q_pal2 [3]  = '{2'b01, 2'b11, 2'b11};
  logic [1:0] exp_seq [8] = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pixel stream of one whole line, built from the ROM contents.
  task automatic push_line(input logic [4:0] r, input logic [2:0] f);
    logic [7:0] t, p0, p1, atb, shifted;
    logic [1:0] pal;
    exp_q.delete();
    for (int c = 0; c < TILES_X; c++) begin
      logic [4:0] cc;
      int q;
      cc      = 5'(c);
      t       = nt_rom[{r, cc}];
      atb     = at_rom[{1'b0, r[4:2], cc[4:2]}];
      q       = 2 * int'({r[1], cc[1]});
      shifted = atb >> q;
      pal     = shifted[1:0];
      p0      = pt_rom[{t, 1'b0, f}];
      p1      = pt_rom[{t, 1'b1, f}];
      for (int b = 7; b >= 0; b--) exp_q.push_back({pal, p1[b], p0[b]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pix_adv && bus.pix_valid && !bus.line_start) begin
        if (pix_seen < 256) begin
          obs_pal[pix_seen] = bus.pix_pal;
          obs_col[pix_seen] = bus.pix_color;
        end
        check("pixel", {bus.pix_pal, bus.pix_color},
              (exp_q.size() == 0) ? 8'hFF : {4'h0, exp_q.pop_front()});
        pix_seen++;
      end
      if (bus.underrun)  under_cnt++;
      if (bus.line_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_line(input logic [4:0] r, input logic [2:0] f, input logic adv);
    @(posedge clk); #1;
    bus.line_start = 1'b1;
    bus.row        = r;
    bus.fine_y     = f;
    bus.pix_adv    = adv;
    push_line(r, f);
    pix_seen  = 0;
    under_cnt = 0;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
  endtask

  task automatic wait_pixels(input int n, input int budget);
    for (int i = 0; i < budget && pix_seen < n; i++) @(posedge clk);
    check("pixel_wait_timeout", 64'(pix_seen >= n), 64'd1);
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    for (int i = 0; i < budget && done_cnt == start_cnt; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("line_done_count", 64'(done_cnt - start_cnt), 64'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) nt_rom[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 128; i++)  at_rom[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4096; i++) pt_rom[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    logic [11:0] exp_pt;
    rst_n          = 1'b0;
    bus.line_start = 1'b0;
    bus.row        = '0;
    bus.fine_y     = '0;
    bus.pix_adv    = 1'b0;
    fill_random();

    // Reset with random inputs: everything stays at zero / IDLE.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.line_start = 1'($urandom_range(0, 1));
      bus.row        = 5'($urandom_range(0, 29));
      bus.fine_y     = 3'($urandom_range(0, 7));
      bus.pix_adv    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_outputs", {bus.nt_addr, bus.at_addr, bus.pt_addr, bus.pix_color,
                              bus.pix_pal, bus.pix_valid, bus.underrun, bus.line_done}, 64'd0);
      check("reset_state", 64'(dbg_state), 64'(S_IDLE));
    end
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    bus.pix_adv    = 1'b0;
    rst_n          = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Fetch sequence, row 5 fine_y 3, no consumer.
    d0 = done_cnt;
    start_line(5'd5, 3'd3, 1'b0);
    exp_pt = {nt_rom[160], 1'b0, 3'd3};
    @(negedge clk);
    check("nt_addr_c1", 64'(bus.nt_addr), 64'd160);
    check("state_c1", 64'(dbg_state), 64'(S_NT));
    @(negedge clk);
    check("at_addr_c2", 64'(bus.at_addr), 64'h08);
    @(negedge clk);
    check("pt0_addr_c3", 64'(bus.pt_addr), 64'(exp_pt));
    check("valid_c3", 64'(bus.pix_valid), 64'd0);
    exp_pt[3] = 1'b1;
    @(negedge clk);
    check("pt1_addr_c4", 64'(bus.pt_addr), 64'(exp_pt));
    check("valid_c4", 64'(bus.pix_valid), 64'd0);
    @(negedge clk);
    check("valid_c5", 64'(bus.pix_valid), 64'd1);
    check("nt_addr_c5", 64'(bus.nt_addr), 64'd161);
    repeat (8) @(negedge clk);
    check("state_park_wait", 64'(dbg_state), 64'(S_WAIT));
    check("nt_addr_hold", 64'(bus.nt_addr), 64'd161);
    @(posedge clk); #1;
    bus.pix_adv = 1'b1;
    wait_done(d0, 600);
    check("line_pixels", 64'(pix_seen), 64'd256);
    check("line_queue_left", 64'(exp_q.size()), 64'd0);
    check("line_underrun", 64'(under_cnt), 64'd0);
    @(negedge clk);
    check("valid_after_done", 64'(bus.pix_valid), 64'd0);
    check("state_after_done", 64'(dbg_state), 64'(S_IDLE));

    // Attribute quadrants with at_data = 0xE4 everywhere.
    for (int i = 0; i < 128; i++) at_rom[i] = 8'hE4;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt;
      start_line(q_rows[k], 3'($urandom_range(0, 7)), 1'b1);
      wait_done(d0, 600);
      check("quad_pal_col0", 64'(obs_pal[0]), 64'(q_pal0[k]));
      check("quad_pal_col2", 64'(obs_pal[16]), 64'(q_pal2[k]));
    end

    // Full line with pix_adv from line_start, planes 0xF0 / 0xAA.
    for (int i = 0; i < 4096; i++) pt_rom[i] = i[3] ? 8'hAA : 8'hF0;
    d0 = done_cnt;
    start_line(5'd7, 3'd1, 1'b1);
    wait_done(d0, 600);
    check("full_pixels", 64'(pix_seen), 64'd256);
    check("full_underrun", 64'(under_cnt), 64'd5);
    for (int b = 0; b < 8; b++) begin
      check("colour_seq_first", 64'(obs_col[b]), 64'(exp_seq[b]));
      check("colour_seq_last", 64'(obs_col[248 + b]), 64'(exp_seq[b]));
    end
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    check("idle_no_underrun", 64'(under_cnt), 64'd5);
    check("idle_no_done", 64'(done_cnt - d0), 64'd0);

    // Abort mid-line with a new line_start.
    fill_random();
    d0 = done_cnt;
    start_line(5'd9, 3'd5, 1'b1);
    wait_pixels(100, 300);
    start_line(5'd12, 3'd6, 1'b1);
    @(negedge clk);
    check("abort_valid_c1", 64'(bus.pix_valid), 64'd0);
    check("abort_state_c1", 64'(dbg_state), 64'(S_NT));
    check("abort_nt_addr", 64'(bus.nt_addr), 64'd384);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      check("abort_valid_pre", 64'(bus.pix_valid), 64'd0);
    end
    @(negedge clk);
    check("abort_valid_c5", 64'(bus.pix_valid), 64'd1);
    wait_done(d0, 600);
    check("abort_pixels", 64'(pix_seen), 64'd256);
    check("abort_queue_left", 64'(exp_q.size()), 64'd0);

    // Reset mid-line.
    d0 = done_cnt;
    start_line(5'd4, 3'd2, 1'b1);
    wait_pixels(50, 300);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_outputs", {bus.nt_addr, bus.at_addr, bus.pt_addr, bus.pix_color,
                               bus.pix_pal, bus.pix_valid, bus.underrun, bus.line_done}, 64'd0);
    check("midreset_state", 64'(dbg_state), 64'(S_IDLE));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    check("midreset_no_valid", 64'(bus.pix_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
